// File: rtl/tpu_result_drain.sv
// tpu_result_drain: captures the systolic array's LANES result words once per
// completed computation and streams the first n = min(matrix_N, LANES) of
// them out over a valid/ready interface, one word per beat, with lane index.
//
// Optional feature macro: TPU_DRAIN_RELU_EN (when defined, negative words are
// emitted as zero; the capture buffer still holds raw values).
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   matrix_N   requested result lane count, sampled at capture (clamped to LANES)
//   arr_ready  array completion flag (level, sticky until reset)
//   P          array result words, stable while arr_ready is high
//   out_valid  output beat valid
//   out_ready  consumer accepts the beat
//   out_data   result word of the current beat
//   out_idx    lane index of the current beat
//   out_last   final beat of the result set
//   busy       high while capturing, draining or signalling done
//   done       one-cycle pulse after the last beat is accepted
module tpu_result_drain #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LANES  = 16,
  localparam int unsigned IDX_W = $clog2(LANES)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [5:0]                    matrix_N,
  input  logic                          arr_ready,
  input  logic [LANES-1:0][DATA_W-1:0]  P,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             out_data,
  output logic [IDX_W-1:0]              out_idx,
  output logic                          out_last,
  output logic                          busy,
  output logic                          done
);

  // n ranges 0..LANES, so it needs one more bit than a lane index.
  localparam int unsigned CNT_W = $clog2(LANES + 1);
  localparam logic [5:0]       LanesN = 6'(LANES);
  localparam logic [CNT_W-1:0] LanesC = CNT_W'(LANES);

  typedef enum logic [2:0] {
    StIdle,
    StCapture,
    StDrain,
    StDone,
    StWaitLow
  } state_e;

  state_e                         state_q, state_d;
  logic [IDX_W-1:0]               k_q, k_d;
  logic [CNT_W-1:0]               n_q, n_d;
  logic [LANES-1:0][DATA_W-1:0]   res_q;
  logic                           cap_en;
  logic [CNT_W-1:0]               n_clamp;
  logic                           is_last;
  logic [DATA_W-1:0]              word;

  assign n_clamp = (matrix_N > LanesN) ? LanesC : matrix_N[CNT_W-1:0];
  // n_q >= 1 whenever we are in StDrain, so n_q - 1 cannot wrap there.
  assign is_last = (state_q == StDrain) && (CNT_W'(k_q) == (n_q - CNT_W'(1)));
  assign word    = res_q[k_q];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      k_q     <= '0;
      n_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      n_q     <= n_d;
      if (cap_en) res_q <= P;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    n_d     = n_q;
    cap_en  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (arr_ready) state_d = StCapture;
      end
      StCapture: begin
        cap_en  = 1'b1;
        n_d     = n_clamp;
        k_d     = '0;
        state_d = (n_clamp == '0) ? StDone : StDrain;
      end
      StDrain: begin
        if (out_ready) begin
          if (is_last) state_d = StDone;
          else         k_d     = k_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StWaitLow;
      end
      StWaitLow: begin
        // arr_ready is sticky; wait for it to fall so the same result is not recaptured.
        if (!arr_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs depend only on registered state and the register-indexed buffer mux.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_idx   = '0;
    out_last  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    if (state_q == StDrain) begin
      out_valid = 1'b1;
      out_idx   = k_q;
      out_last  = is_last;
`ifdef TPU_DRAIN_RELU_EN
      out_data  = word[DATA_W-1] ? '0 : word;
`else
      out_data  = word;
`endif
    end
    busy = (state_q == StCapture) || (state_q == StDrain) || (state_q == StDone);
    done = (state_q == StDone);
  end

endmodule
